rf_wr_arbiter: RTL and testbench

- Owns the single register-file write port and shares it among NUM_REQ result sources (ALU, multiplier, shifter, data-memory load).
- Arbitrates round-robin with a valid/ready handshake, and registers the winner's address and data onto the regfile write interface.
- Keeps a pending-write scoreboard so the program sequencer can stall reads of registers whose results are still in flight.

---
 rtl/rf_wr_arbiter_pkg.sv | 19 +
 rtl/rf_wr_arbiter_if.sv | 17 +
 rtl/rf_wr_arbiter_rr_arbiter.sv | 54 +++++
 rtl/rf_wr_arbiter.sv | 86 ++++++++
 tb/tb_rf_wr_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Requester index map, default widths and a small width helper.
package rf_wr_arbiter_pkg;

  localparam int RF_DATA_WIDTH    = 16;
  localparam int RF_ADDRESS_WIDTH = 4;
  localparam int RF_NUM_REQ       = 4;

  localparam int REQ_ALU = 0;
  localparam int REQ_MUL = 1;
  localparam int REQ_SHF = 2;
  localparam int REQ_DM  = 3;

  // Index width for n requesters; never narrower than one bit.
  function automatic int rf_idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Requester-side write bus shared by all result sources.
// Handshake: a source raises req_valid[i] with A/d held stable; the transfer
//   happens on the rising edge where req_valid[i] & req_ready[i]. req_ready is
//   one-hot, combinational, and depends only on req_valid and arbiter state.
interface rf_wr_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 16
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_A;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_d;
  logic [NUM_REQ-1:0]               req_ready;

  modport master (output req_valid, output req_A, output req_d, input  req_ready);
  modport slave  (input  req_valid, input  req_A, input  req_d, output req_ready);
endinterface

// File: rtl/rf_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts after the last winner.
// With RF_WR_ARB_FIXED_PRIO_EN defined it becomes fixed lowest-index priority.
module rr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int IW      = rf_idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
`ifndef RF_WR_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]      last,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  assign any = |valid;

`ifdef RF_WR_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest valid index is the last one written.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] cand;
  logic          found;

  // Wrap by explicit compare so non-power-of-two NUM_REQ works.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Build option: RF_WR_ARB_FIXED_PRIO_EN selects fixed priority (no pointer).
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int NUM_REQ       = RF_NUM_REQ
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rf_wr_arbiter_if.slave              req,
  output logic                        arb_rf_En,
  output logic [ADDRESS_WIDTH-1:0]    arb_rf_wrtA,
  output logic [DATA_WIDTH-1:0]       arb_rf_d,
  input  logic                        ps_rsv_En,
  input  logic [ADDRESS_WIDTH-1:0]    ps_rsv_A,
  input  logic [ADDRESS_WIDTH-1:0]    ps_rf_xA,
  input  logic [ADDRESS_WIDTH-1:0]    ps_rf_yA,
  output logic                        arb_ps_xbusy,
  output logic                        arb_ps_ybusy,
  output logic [2**ADDRESS_WIDTH-1:0] arb_ps_pending
);

  localparam int IW   = rf_idx_width(NUM_REQ);
  localparam int NREG = 2 ** ADDRESS_WIDTH;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [NREG-1:0]    pending;
  logic [NREG-1:0]    pending_next;

`ifndef RF_WR_ARB_FIXED_PRIO_EN
  logic [IW-1:0] last;

  // Reset to NUM_REQ-1 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last <= IW'(NUM_REQ - 1);
    else if (win_any) last <= win_idx;
  end
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .valid (req.req_valid),
`ifndef RF_WR_ARB_FIXED_PRIO_EN
    .last  (last),
`endif
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign req.req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_rf_En   <= 1'b0;
      arb_rf_wrtA <= '0;
      arb_rf_d    <= '0;
    end else begin
      arb_rf_En <= win_any;
      if (win_any) begin
        arb_rf_wrtA <= req.req_A[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        arb_rf_d    <= req.req_d[win_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Clear on the regfile-write edge, then set: a new reservation wins.
  always_comb begin
    pending_next = pending;
    if (arb_rf_En) pending_next[arb_rf_wrtA] = 1'b0;
    if (ps_rsv_En) pending_next[ps_rsv_A]    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  assign arb_ps_pending = pending;
  assign arb_ps_xbusy   = pending[ps_rf_xA];
  assign arb_ps_ybusy   = pending[ps_rf_yA];

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter.
// Honours RF_WR_ARB_FIXED_PRIO_EN in its expected grant sequences.
module tb_rf_wr_arbiter;
  import rf_wr_arbiter_pkg::*;

  localparam int NR = RF_NUM_REQ;
  localparam int AW = RF_ADDRESS_WIDTH;
  localparam int DW = RF_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic          ps_rsv_En;
  logic [AW-1:0] ps_rsv_A, ps_rf_xA, ps_rf_yA;
  logic          arb_rf_En;
  logic [AW-1:0] arb_rf_wrtA;
  logic [DW-1:0] arb_rf_d;
  logic          arb_ps_xbusy, arb_ps_ybusy;
  logic [2**AW-1:0] arb_ps_pending;

  int checks = 0;
  int failures = 0;
  logic [NR-1:0] exp_q[$];

  rf_wr_arbiter_if #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) req_if ();

  rf_wr_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req_if),
    .arb_rf_En      (arb_rf_En),
    .arb_rf_wrtA    (arb_rf_wrtA),
    .arb_rf_d       (arb_rf_d),
    .ps_rsv_En      (ps_rsv_En),
    .ps_rsv_A       (ps_rsv_A),
    .ps_rf_xA       (ps_rf_xA),
    .ps_rf_yA       (ps_rf_yA),
    .arb_ps_xbusy   (arb_ps_xbusy),
    .arb_ps_ybusy   (arb_ps_ybusy),
    .arb_ps_pending (arb_ps_pending)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_if.req_A[i*AW +: AW] = a;
    req_if.req_d[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    req_if.req_valid = '0;
    req_if.req_A     = '0;
    req_if.req_d     = '0;
    ps_rsv_En = 1'b0;
    ps_rsv_A  = '0;
    ps_rf_xA  = '0;
    ps_rf_yA  = '0;
  endtask

  // Enters and returns just after a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (arb_rf_En !== 1'b0) begin failures++; $display("FAIL reset_en: got %b want 0", arb_rf_En); end
    checks++; if (arb_rf_wrtA !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", arb_rf_wrtA); end
    checks++; if (arb_rf_d !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", arb_rf_d); end
    checks++; if (arb_ps_pending !== '0) begin failures++; $display("FAIL reset_pending: got %h want 0", arb_ps_pending); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_if.req_ready !== 4'b0000) begin failures++; $display("FAIL idle_ready: got %b want 0000", req_if.req_ready); end
    @(posedge clk); #1;
    checks++; if (arb_rf_En !== 1'b0) begin failures++; $display("FAIL idle_en: got %b want 0", arb_rf_En); end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(REQ_MUL, 4'h5, 16'hBEEF);
    req_if.req_valid = 4'b0010;
    #1;
    checks++; if (req_if.req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready: got %b want 0010", req_if.req_ready); end
    @(posedge clk); #1;
    checks++; if (arb_rf_En !== 1'b1) begin failures++; $display("FAIL single_en: got %b want 1", arb_rf_En); end
    checks++; if (arb_rf_wrtA !== 4'h5) begin failures++; $display("FAIL single_addr: got %h want 5", arb_rf_wrtA); end
    checks++; if (arb_rf_d !== 16'hBEEF) begin failures++; $display("FAIL single_data: got %h want beef", arb_rf_d); end
    @(negedge clk);
    req_if.req_valid = 4'b0000;
    #1;
    checks++; if (req_if.req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_idle: got %b want 0000", req_if.req_ready); end
    @(posedge clk); #1;
    checks++; if (arb_rf_En !== 1'b0) begin failures++; $display("FAIL single_en_drop: got %b want 0", arb_rf_En); end
    checks++; if (arb_rf_wrtA !== 4'h5 || arb_rf_d !== 16'hBEEF) begin failures++; $display("FAIL single_hold: got %h/%h want 5/beef", arb_rf_wrtA, arb_rf_d); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_g;
    int widx;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(8 + i), DW'(16'hA000 + i));
    for (int k = 0; k < 8; k++) begin
`ifdef RF_WR_ARB_FIXED_PRIO_EN
      exp_q.push_back(4'b0001);
`else
      exp_q.push_back(4'(1 << (k % NR)));
`endif
    end
    req_if.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_g = exp_q.pop_front();
      widx = 0;
      for (int i = 0; i < NR; i++) if (exp_g[i]) widx = i;
      checks++; if (req_if.req_ready !== exp_g) begin failures++; $display("FAIL fair_ready[%0d]: got %b want %b", k, req_if.req_ready, exp_g); end
      @(posedge clk); #1;
      checks++; if (arb_rf_En !== 1'b1 || arb_rf_wrtA !== AW'(8 + widx) || arb_rf_d !== DW'(16'hA000 + widx)) begin
        failures++; $display("FAIL fair_write[%0d]: got en=%b a=%h d=%h want en=1 a=%h d=%h", k, arb_rf_En, arb_rf_wrtA, arb_rf_d, AW'(8 + widx), DW'(16'hA000 + widx));
      end
      @(negedge clk);
    end
    req_if.req_valid = 4'b0000;
    checks++; if (arb_ps_pending !== '0) begin failures++; $display("FAIL fair_nonpending: got %h want 0", arb_ps_pending); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    ps_rsv_En = 1'b1; ps_rsv_A = 4'd3; ps_rf_xA = 4'd3; ps_rf_yA = 4'd4;
    #1;
    checks++; if (arb_ps_xbusy !== 1'b0) begin failures++; $display("FAIL sb_pre_reserve: got %b want 0", arb_ps_xbusy); end
    @(posedge clk); #1;
    checks++; if (arb_ps_pending !== 16'h0008) begin failures++; $display("FAIL sb_reserved: got %h want 0008", arb_ps_pending); end
    @(negedge clk);
    ps_rsv_En = 1'b0;
    set_req(REQ_ALU, 4'd3, 16'h1234);
    req_if.req_valid = 4'b0001;
    #1;
    checks++; if (arb_ps_xbusy !== 1'b1 || arb_ps_ybusy !== 1'b0) begin failures++; $display("FAIL sb_busy: got x=%b y=%b want x=1 y=0", arb_ps_xbusy, arb_ps_ybusy); end
    @(posedge clk); #1;
    checks++; if (arb_rf_En !== 1'b1 || arb_rf_wrtA !== 4'd3 || arb_ps_xbusy !== 1'b1) begin failures++; $display("FAIL sb_en_cycle: got en=%b a=%h x=%b want en=1 a=3 x=1", arb_rf_En, arb_rf_wrtA, arb_ps_xbusy); end
    @(negedge clk);
    req_if.req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (arb_ps_xbusy !== 1'b0 || arb_ps_pending !== '0) begin failures++; $display("FAIL sb_cleared: got x=%b pend=%h want x=0 pend=0", arb_ps_xbusy, arb_ps_pending); end
    @(negedge clk);
  endtask

  task automatic test_same_edge();
    do_reset();
    ps_rf_yA = 4'd7;
    ps_rsv_En = 1'b1; ps_rsv_A = 4'd7;
    set_req(REQ_SHF, 4'd7, 16'h7777);
    req_if.req_valid = 4'b0100;
    @(posedge clk); #1;
    checks++; if (arb_ps_pending !== 16'h0080 || arb_rf_En !== 1'b1 || arb_rf_wrtA !== 4'd7) begin failures++; $display("FAIL same_setup: got pend=%h en=%b a=%h want 0080/1/7", arb_ps_pending, arb_rf_En, arb_rf_wrtA); end
    @(negedge clk);
    req_if.req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (arb_ps_pending !== 16'h0080 || arb_ps_ybusy !== 1'b1) begin failures++; $display("FAIL same_set_wins: got pend=%h y=%b want 0080/1", arb_ps_pending, arb_ps_ybusy); end
    @(negedge clk);
    ps_rsv_En = 1'b0;
    req_if.req_valid = 4'b0100;
    @(posedge clk); #1;
    checks++; if (arb_ps_pending !== 16'h0080) begin failures++; $display("FAIL same_hold: got %h want 0080", arb_ps_pending); end
    @(negedge clk);
    req_if.req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (arb_ps_pending !== '0 || arb_ps_ybusy !== 1'b0) begin failures++; $display("FAIL same_final_clear: got pend=%h y=%b want 0/0", arb_ps_pending, arb_ps_ybusy); end
    @(negedge clk);
  endtask

  task automatic test_skipped();
    logic [NR-1:0] exp_g [3];
`ifdef RF_WR_ARB_FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b1000, 4'b0001, 4'b1000};
`endif
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i), DW'(16'hC000 + i));
    req_if.req_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_if.req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_if.req_ready !== exp_g[k]) begin failures++; $display("FAIL skip_ready[%0d]: got %b want %b", k, req_if.req_ready, exp_g[k]); end
      @(posedge clk); #1;
      checks++; if (arb_rf_wrtA !== ((exp_g[k] == 4'b1000) ? 4'd3 : 4'd0)) begin failures++; $display("FAIL skip_addr[%0d]: got %h", k, arb_rf_wrtA); end
      @(negedge clk);
    end
    req_if.req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), DW'(16'h5A00 + i));
    req_if.req_valid = 4'b1111;
    ps_rsv_En = 1'b1; ps_rsv_A = 4'd5;
    @(posedge clk); #1;
    checks++; if (arb_rf_En !== 1'b1 || arb_ps_pending !== 16'h0020) begin failures++; $display("FAIL mid_before: got en=%b pend=%h want 1/0020", arb_rf_En, arb_ps_pending); end
    ps_rsv_En = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (arb_rf_En !== 1'b0 || arb_rf_wrtA !== '0 || arb_rf_d !== '0) begin failures++; $display("FAIL mid_regs: got en=%b a=%h d=%h want 0/0/0", arb_rf_En, arb_rf_wrtA, arb_rf_d); end
    checks++; if (arb_ps_pending !== '0) begin failures++; $display("FAIL mid_pending: got %h want 0", arb_ps_pending); end
    checks++; if (req_if.req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr: got %b want 0001", req_if.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_scoreboard();
    test_same_edge();
    test_skipped();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
